// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates the branch condition, forms target/fall-through PC,
// flags mispredictions, and presents the result through a registered valid/ready slot.
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  input  logic              usigned,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       offset,
  input  logic              pred_taken,
  input  logic              flush,
  input  logic              stats_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [ADDR_W-1:0] next_pc,
  output logic              mispredict,
  output logic              bad_op,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  mis_cnt
);

  logic              r_outValid;
  logic              r_taken;
  logic [ADDR_W-1:0] r_nextPc;
  logic              r_mispredict;
  logic              r_badOp;
  logic [CNT_W-1:0]  r_brCnt;
  logic [CNT_W-1:0]  r_takenCnt;
  logic [CNT_W-1:0]  r_misCnt;

  logic              w_cond;
  logic              w_badOp;
  logic              w_taken;
  logic              w_mispredict;
  logic [ADDR_W-1:0] w_offExt;
  logic [ADDR_W-1:0] w_pcPlus4;
  logic [ADDR_W-1:0] w_target;
  logic              w_accept;
  logic              w_xfer;

  assign w_badOp      = op[3];
  assign w_offExt     = ADDR_W'($signed(offset));
  assign w_pcPlus4    = pc + ADDR_W'(4);
  assign w_target     = w_pcPlus4 + (w_offExt << 2);
  assign w_taken      = !w_badOp && w_cond;
  assign w_mispredict = !w_badOp && (w_taken != pred_taken);

  always_comb begin
    w_cond = 1'b0;
    case (op[2:0])
      3'b000:  w_cond = (a == b);
      3'b001:  w_cond = (a != b);
      3'b010:  w_cond = ($signed(a) <= 0);
      3'b011:  w_cond = ($signed(a) > 0);
      3'b100:  w_cond = ($signed(a) < 0);
      3'b101:  w_cond = ($signed(a) >= 0);
      3'b110:  w_cond = usigned ? (a < b) : ($signed(a) < $signed(b));
      3'b111:  w_cond = usigned ? (a >= b) : ($signed(a) >= $signed(b));
      default: w_cond = 1'b0;
    endcase
  end

  assign in_ready = !flush && (!r_outValid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_outValid && out_ready && !flush;

  // Flush drops the held result and blocks the load; otherwise a load may overlap a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid   <= 1'b0;
      r_taken      <= 1'b0;
      r_nextPc     <= '0;
      r_mispredict <= 1'b0;
      r_badOp      <= 1'b0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (w_accept) begin
      r_outValid   <= 1'b1;
      r_taken      <= w_taken;
      r_nextPc     <= w_taken ? w_target : w_pcPlus4;
      r_mispredict <= w_mispredict;
      r_badOp      <= w_badOp;
    end else if (w_xfer) begin
      r_outValid <= 1'b0;
    end
  end

  // Statistics count only results actually handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_brCnt    <= '0;
      r_takenCnt <= '0;
      r_misCnt   <= '0;
    end else if (w_xfer) begin
      if (r_brCnt != '1)
        r_brCnt <= r_brCnt + CNT_W'(1);
      if (r_taken && (r_takenCnt != '1))
        r_takenCnt <= r_takenCnt + CNT_W'(1);
      if (r_mispredict && (r_misCnt != '1))
        r_misCnt <= r_misCnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_outValid;
  assign taken      = r_taken;
  assign next_pc    = r_nextPc;
  assign mispredict = r_mispredict;
  assign bad_op     = r_badOp;
  assign br_cnt     = r_brCnt;
  assign taken_cnt  = r_takenCnt;
  assign mis_cnt    = r_misCnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: two instances (16-bit and 2-bit counters)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_branch_resolve_unit;

  typedef struct {
    logic        taken;
    logic [31:0] nextPc;
    logic        mis;
    logic        bad;
  } resultT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] aIn = '0;
  logic [31:0] bIn = '0;
  logic [3:0]  opIn = '0;
  logic        usIn = 1'b0;
  logic [31:0] pcIn = '0;
  logic [15:0] offIn = '0;
  logic        predIn = 1'b0;
  logic        flushIn = 1'b0;
  logic        clrIn = 1'b0;
  logic        outReady = 1'b0;

  logic        inReady0, outValid0, taken0, mis0, bad0;
  logic [31:0] nextPc0;
  logic [15:0] brCnt0, takenCnt0, misCnt0;
  logic        inReady1, outValid1, taken1, mis1, bad1;
  logic [31:0] nextPc1;
  logic [1:0]  brCnt1, takenCnt1, misCnt1;

  int testsRun = 0;
  int failures = 0;

  resultT expQ[$];
  logic   issuedNow = 1'b0;
  logic   armed = 1'b0;
  logic   justReset = 1'b0;
  int     brM0, takenM0, misM0;
  int     brM1, takenM1, misM1;

  always #5 clk = ~clk;

  branch_resolve_unit u0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
    .a(aIn), .b(bIn), .op(opIn), .usigned(usIn), .pc(pcIn), .offset(offIn),
    .pred_taken(predIn), .flush(flushIn), .stats_clr(clrIn),
    .out_valid(outValid0), .out_ready(outReady), .taken(taken0), .next_pc(nextPc0),
    .mispredict(mis0), .bad_op(bad0), .br_cnt(brCnt0), .taken_cnt(takenCnt0), .mis_cnt(misCnt0)
  );

  branch_resolve_unit #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1),
    .a(aIn), .b(bIn), .op(opIn), .usigned(usIn), .pc(pcIn), .offset(offIn),
    .pred_taken(predIn), .flush(flushIn), .stats_clr(clrIn),
    .out_valid(outValid1), .out_ready(outReady), .taken(taken1), .next_pc(nextPc1),
    .mispredict(mis1), .bad_op(bad1), .br_cnt(brCnt1), .taken_cnt(takenCnt1), .mis_cnt(misCnt1)
  );

  // Reference: branch rules evaluated on plain 64-bit integers.
  function automatic resultT refModel(input logic [31:0] av, input logic [31:0] bv,
                                      input logic [3:0] opv, input logic us,
                                      input logic [31:0] pcv, input logic [15:0] offv,
                                      input logic pred);
    resultT r;
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
    longint sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
    longint so = (offv >= 16'h8000) ? longint'(offv) - 64'sd65536 : longint'(offv);
    longint fall = (longint'(pcv) + 4) & 64'shFFFFFFFF;
    longint targ = (longint'(pcv) + 4 + so * 4) & 64'shFFFFFFFF;
    logic t = 1'b0;
    r.bad = (opv >= 4'd8);
    case (opv)
      4'd0: t = (ua == ub);
      4'd1: t = (ua != ub);
      4'd2: t = (sa <= 0);
      4'd3: t = (sa > 0);
      4'd4: t = (sa < 0);
      4'd5: t = (sa >= 0);
      4'd6: t = us ? (ua < ub) : (sa < sb);
      4'd7: t = us ? (ua >= ub) : (sa >= sb);
      default: t = 1'b0;
    endcase
    r.taken  = t;
    r.nextPc = t ? targ[31:0] : fall[31:0];
    r.mis    = r.bad ? 1'b0 : (t != pred);
    return r;
  endfunction

  function automatic int satInc(input int v, input int inc, input int lim);
    return (v + inc > lim) ? lim : v + inc;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs; an accepted request pushes its expected result.
  task automatic applyStimulus(input logic v, input logic [31:0] av, input logic [31:0] bv,
                               input logic [3:0] opv, input logic us, input logic [31:0] pcv,
                               input logic [15:0] offv, input logic pred, input logic fl,
                               input logic clr, input logic ordy, input logic rs);
    logic acc;
    @(posedge clk);
    #1;
    inValid = v; aIn = av; bIn = bv; opIn = opv; usIn = us; pcIn = pcv;
    offIn = offv; predIn = pred; flushIn = fl; clrIn = clr; outReady = ordy; rst = rs;
    acc = !rs && v && !fl && (expQ.size() == 0 || ordy);
    if (acc) expQ.push_back(refModel(av, bv, opv, us, pcv, offv, pred));
    issuedNow = acc;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, '0, '0, 4'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic sendReq(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] opv,
                         input logic us, input logic [31:0] pcv, input logic [15:0] offv,
                         input logic pred, input logic ordy);
    applyStimulus(1'b1, av, bv, opv, us, pcv, offv, pred, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: compares DUT outputs with the queue head and counter models each cycle.
  always @(negedge clk) begin
    logic   held;
    resultT e;
    if (rst) begin
      expQ.delete();
      brM0 = 0; takenM0 = 0; misM0 = 0;
      brM1 = 0; takenM1 = 0; misM1 = 0;
      armed = 1'b1;
      justReset = 1'b1;
    end else if (armed) begin
      held = (expQ.size() > (issuedNow ? 1 : 0));
      checkOutput("out_valid", {63'd0, outValid0}, {63'd0, held});
      checkOutput("out_valid_c2", {63'd0, outValid1}, {63'd0, held});
      checkOutput("in_ready", {63'd0, inReady0}, {63'd0, !flushIn && (!held || outReady)});
      checkOutput("in_ready_c2", {63'd0, inReady1}, {63'd0, !flushIn && (!held || outReady)});
      checkOutput("br_cnt", 64'(brCnt0), 64'(brM0));
      checkOutput("taken_cnt", 64'(takenCnt0), 64'(takenM0));
      checkOutput("mis_cnt", 64'(misCnt0), 64'(misM0));
      checkOutput("br_cnt_c2", 64'(brCnt1), 64'(brM1));
      checkOutput("taken_cnt_c2", 64'(takenCnt1), 64'(takenM1));
      checkOutput("mis_cnt_c2", 64'(misCnt1), 64'(misM1));
      if (justReset && !held) begin
        checkOutput("reset_fields", {31'd0, taken0, nextPc0}, 64'd0);
        checkOutput("reset_flags", {62'd0, mis0, bad0}, 64'd0);
      end
      justReset = 1'b0;
      if (held && outValid0 && outValid1) begin
        e = expQ[0];
        checkOutput("taken", {63'd0, taken0}, {63'd0, e.taken});
        checkOutput("next_pc", 64'(nextPc0), 64'(e.nextPc));
        checkOutput("mispredict", {63'd0, mis0}, {63'd0, e.mis});
        checkOutput("bad_op", {63'd0, bad0}, {63'd0, e.bad});
        checkOutput("fields_c2", {29'd0, taken1, mis1, bad1, nextPc1},
                    {29'd0, e.taken, e.mis, e.bad, e.nextPc});
      end
      if (flushIn) begin
        expQ.delete();
      end else if (held && outReady) begin
        e = expQ.pop_front();
        brM0 = satInc(brM0, 1, 65535);
        takenM0 = satInc(takenM0, int'(e.taken), 65535);
        misM0 = satInc(misM0, int'(e.mis), 65535);
        brM1 = satInc(brM1, 1, 3);
        takenM1 = satInc(takenM1, int'(e.taken), 3);
        misM1 = satInc(misM1, int'(e.mis), 3);
      end
      if (clrIn) begin
        brM0 = 0; takenM0 = 0; misM0 = 0;
        brM1 = 0; takenM1 = 0; misM1 = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    repeat (2) applyStimulus(1'b0, '0, '0, 4'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    sendReq(32'h0000_1234, 32'h0000_1234, 4'b0000, 1'b0, 32'h0040_0000, 16'h0003, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    sendReq(32'hFFFF_FFFF, 32'h1, 4'b0110, 1'b0, 32'h100, 16'h10, 1'b0, 1'b1);
    sendReq(32'hFFFF_FFFF, 32'h1, 4'b0110, 1'b1, 32'h100, 16'h10, 1'b1, 1'b1);
    sendReq(32'h8000_0000, 32'h0, 4'b0101, 1'b0, 32'h200, 16'h20, 1'b0, 1'b1);
    sendReq(32'h0, 32'h0, 4'b0011, 1'b1, 32'h300, 16'h30, 1'b0, 1'b1);
    sendReq(32'h0, 32'h0, 4'b0010, 1'b0, 32'h400, 16'h40, 1'b1, 1'b1);
    sendReq(32'h5, 32'h6, 4'b0001, 1'b0, 32'h0000_0000, 16'hFFFF, 1'b1, 1'b1);
    sendReq(32'h5, 32'h5, 4'b0001, 1'b0, 32'hFFFF_FFFC, 16'h0001, 1'b0, 1'b1);
    idle(1'b1);

    sendReq(32'h1, 32'h1, 4'b0000, 1'b0, 32'h1000, 16'h1, 1'b0, 1'b0);
    sendReq(32'h2, 32'h3, 4'b0001, 1'b0, 32'h2000, 16'h2, 1'b0, 1'b0);
    sendReq(32'h2, 32'h3, 4'b0001, 1'b0, 32'h2000, 16'h2, 1'b0, 1'b0);
    sendReq(32'h2, 32'h3, 4'b0001, 1'b0, 32'h2000, 16'h2, 1'b0, 1'b1);
    sendReq(32'h7, 32'h3, 4'b0111, 1'b0, 32'h3000, 16'h3, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    sendReq(32'h9, 32'h9, 4'b0000, 1'b0, 32'h4000, 16'h4, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h9, 32'h9, 4'b0000, 1'b0, 32'h4100, 16'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    sendReq(32'h9, 32'h9, 4'b1010, 1'b0, 32'h5000, 16'h8, 1'b1, 1'b1);
    idle(1'b1);

    applyStimulus(1'b0, '0, '0, 4'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) sendReq(32'hAB, 32'hAB, 4'b0000, 1'b0, 32'h6000, 16'h1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    sendReq(32'h1, 32'h2, 4'b0110, 1'b0, 32'h7000, 16'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 4'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    sendReq(32'h3, 32'h3, 4'b0000, 1'b0, 32'h8000, 16'h2, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 4'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = ra; end
        1: begin ra = $urandom_range(0, 4) - 2; rb = $urandom_range(0, 4) - 2; end
        2: begin ra = {$urandom_range(0, 1) == 1, 31'd0}; rb = $urandom_range(0, 1); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, 4'($urandom_range(0, 15)),
                    1'($urandom), $urandom, 16'($urandom), 1'($urandom),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    end
    repeat (3) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch-resolution stage for the CPU datapath. Evaluates a branch condition on two register operands, computes the taken target and fall-through PC, and flags a misprediction against a supplied prediction bit. Results leave through a registered valid/ready stage, and saturating statistics counters are kept alongside. The unit sits between operand read and PC update, replacing the purely combinational branch-condition check; it adds BNE/BGE, flush, handshaking and counters.

## Interface
- DATA_W, 32: operand width; all signed comparisons are two's complement at this width
- ADDR_W, 32: PC and target width
- CNT_W, 16: statistics counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  branch request present
- in_ready  out  1  unit accepts request this cycle
- a, b  in  DATA_W each  operands (rs, rt)
- op  in  4  condition code (see Operation)
- usigned  in  1  unsigned compare for BLT/BGE
- pc  in  ADDR_W  address of branch instruction
- offset  in  16  signed word offset
- pred_taken  in  1  front-end prediction
- flush  in  1  discard held result and block acceptance this cycle
- stats_clr  in  1  zero all counters
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- taken  out  1  condition result
- next_pc  out  ADDR_W  taken ? target : pc+4
- mispredict  out  1  taken != pred_taken
- bad_op  out  1  op was illegal
- br_cnt, taken_cnt, mis_cnt  out  CNT_W each  saturating counters

## Operation
- op codes; other bits ignored only as stated:
  - 0000 BEQ: a==b
  - 0001 BNE: a!=b
  - 0010 BLEZ: signed a<=0
  - 0011 BGTZ: signed a>0
  - 0100 BLTZ: signed a<0
  - 0101 BGEZ: signed a>=0
  - 0110 BLT: a<b, signed unless usigned=1
  - 0111 BGE: a>=b, signed unless usigned=1
  - 1xxx: illegal; taken=0, bad_op=1, next_pc=pc+4
- usigned is ignored for all ops except 0110/0111.
- target = pc + 4 + (sign_extend(offset) << 2), truncated to ADDR_W (mod 2^ADDR_W); pc+4 also wraps.
- in_ready = !flush && (!out_valid || out_ready).
- Accept when in_valid && in_ready: the output register loads taken, next_pc, mispredict, bad_op, and out_valid goes to 1.
- Transfer when out_valid && out_ready && !flush: out_valid clears unless a new request is accepted the same cycle.
- On transfer, br_cnt increments by 1, taken_cnt by taken, and mis_cnt by mispredict. Each counter saturates at 2^CNT_W−1 with no wrap. Illegal ops count in br_cnt only (taken=0, and mispredict is forced 0 for illegal ops).
- flush: out_valid clears next cycle. Held and incoming requests are discarded and never counted.
- stats_clr: all counters go to 0 next cycle. It takes priority over an increment in the same cycle.
- Priority: rst > flush > normal operation.

## Timing
- Latency: one cycle from acceptance to out_valid.
- Throughput: one branch per cycle while out_ready=1.
- Output fields are stable while out_valid=1 && out_ready=0 (backpressure). in_ready is low during that time.
- Reset values: out_valid=0, taken=0, next_pc=0, mispredict=0, bad_op=0, all counters=0. in_ready=1 after reset when flush=0.
- Reset mid-stream drops the held result without counting it.
- Flush and stats_clr are single-cycle effects. Nothing is stored from the flush cycle.

## Test plan
- BEQ, a=b=0x0000_1234, pc=0x0040_0000, offset=0x0003, pred_taken=0 -> after 1 cycle: taken=1, next_pc=0x0040_0010, mispredict=1. After transfer: br_cnt=1, taken_cnt=1, mis_cnt=1.
- Signed vs unsigned BLT, a=0xFFFF_FFFF, b=0x1: usigned=0 gives taken=1; usigned=1 gives taken=0. BGEZ on a=0x8000_0000 gives taken=0. BGTZ on a=0 gives taken=0, and BLEZ on a=0 gives taken=1.
- Backward branch with wrap, offset=0xFFFF, pc=0x0000_0000 -> next_pc=0x0000_0000 (4−4). pc=0xFFFF_FFFC, not taken -> next_pc=0x0000_0000.
- Backpressure: stream 3 requests with out_ready=0 for 2 cycles. The first result holds steady and in_ready=0. Then raise out_ready: all 3 results emerge in order at one per cycle, and br_cnt=3.
- Flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and counters unchanged. op=1010 -> bad_op=1, taken=0, next_pc=pc+4, mispredict=0.
- CNT_W=2: 5 taken branches -> all counters saturate at 3. stats_clr together with a transfer -> counters read 0 next cycle.
